// File: rtl/note_phase_gen_if.sv
// Bundle of the note handshake and the PHASE/CE oscillator outputs.
//   master : oscillator side (note_phase_gen); drives NOTE_READY, CE, PHASE, INC
//   slave  : controller / sample-stage side; drives NOTE_VALID, NOTE, GATE
interface note_phase_gen_if #(
    parameter int unsigned ACC_W = 24
);
    logic             NOTE_VALID;
    logic [6:0]       NOTE;
    logic             NOTE_READY;
    logic             GATE;
    logic             CE;
    logic [6:0]       PHASE;
    logic [ACC_W-1:0] INC;

    modport master (
        input  NOTE_VALID,
        input  NOTE,
        input  GATE,
        output NOTE_READY,
        output CE,
        output PHASE,
        output INC
    );

    modport slave (
        output NOTE_VALID,
        output NOTE,
        output GATE,
        input  NOTE_READY,
        input  CE,
        input  PHASE,
        input  INC
    );
endinterface

// File: rtl/note_phase_gen.sv
// Note-driven phase generator feeding a wavetable sample stage.
//   - CE: one-cycle strobe every SR_DIV clocks (sample rate).
//   - MIDI note -> phase increment: sequential divide-by-12, semitone table, octave shift.
//   - Phase accumulator advanced on CE; PHASE is its top 7 bits.
// Ports:
//   CLK  : system clock
//   RST  : synchronous, active-high reset
//   bus  : note_phase_gen_if.master (NOTE_VALID/NOTE/NOTE_READY, GATE, CE, PHASE, INC)
module note_phase_gen #(
    parameter int unsigned SR_DIV = 1024,
    parameter int unsigned ACC_W  = 24
) (
    input  logic              CLK,
    input  logic              RST,
    note_phase_gen_if.master  bus
);

    localparam int unsigned CntW = (SR_DIV > 1) ? $clog2(SR_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SR_DIV - 1);

    typedef enum logic [1:0] {StIdle, StDiv, StLookup, StLoad} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [6:0]       rem_q, rem_d;
    logic [3:0]       oct_q, oct_d;
    logic [15:0]      base_q, base_d;
    logic [15:0]      base_lut;
    logic             ce;

    // Sample strobe.
    always_comb begin
        ce    = (cnt_q == CntMax);
        cnt_d = ce ? '0 : cnt_q + CntW'(1);
    end

    // Accumulator: only moves on CE; GATE low parks it at zero.
    always_comb begin
        acc_d = acc_q;
        if (ce) begin
            acc_d = bus.GATE ? acc_q + inc_q : '0;
        end
    end

    // round(0x4000 * 2^(s/12)) for semitone s within the top octave.
    always_comb begin
        case (rem_q[3:0])
            4'd0:    base_lut = 16'h4000;
            4'd1:    base_lut = 16'h43CE;
            4'd2:    base_lut = 16'h47D6;
            4'd3:    base_lut = 16'h4C1C;
            4'd4:    base_lut = 16'h50A3;
            4'd5:    base_lut = 16'h556E;
            4'd6:    base_lut = 16'h5A82;
            4'd7:    base_lut = 16'h5FE4;
            4'd8:    base_lut = 16'h6598;
            4'd9:    base_lut = 16'h6BA2;
            4'd10:   base_lut = 16'h7209;
            4'd11:   base_lut = 16'h78D1;
            default: base_lut = 16'h4000;
        endcase
    end

    // Note conversion FSM.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        oct_d   = oct_q;
        base_d  = base_q;
        inc_d   = inc_q;
        case (state_q)
            StIdle: begin
                if (bus.NOTE_VALID) begin
                    rem_d   = bus.NOTE;
                    oct_d   = 4'd0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                if (rem_q >= 7'd12) begin
                    rem_d = rem_q - 7'd12;
                    oct_d = oct_q + 4'd1;
                end else begin
                    state_d = StLookup;
                end
            end
            StLookup: begin
                base_d  = base_lut;
                state_d = StLoad;
            end
            StLoad: begin
                // oct is 0..10, so the top octave (note 120..127) is unshifted.
                inc_d   = ACC_W'(base_q) >> (4'd10 - oct_q);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            inc_q   <= '0;
            rem_q   <= '0;
            oct_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            inc_q   <= inc_d;
            rem_q   <= rem_d;
            oct_q   <= oct_d;
            base_q  <= base_d;
        end
    end

    assign bus.CE         = ce;
    assign bus.PHASE      = acc_q[ACC_W-1 -: 7];
    assign bus.INC        = inc_q;
    assign bus.NOTE_READY = (state_q == StIdle);

endmodule

// File: tb/tb_note_phase_gen.sv
module tb_note_phase_gen;

    localparam int unsigned SrDiv = 4;
    localparam int unsigned AccW  = 24;

    logic clk = 1'b0;
    logic rst;

    note_phase_gen_if #(.ACC_W(AccW)) bus ();

    note_phase_gen #(
        .SR_DIV (SrDiv),
        .ACC_W  (AccW)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, advanced in step with every clock edge.
    logic [AccW-1:0] m_acc = '0;
    logic [AccW-1:0] m_inc = '0;
    logic [AccW-1:0] m_inc_pend = '0;
    int              m_cnt = 0;
    int              m_load_cnt = 0;

    bit   seen [128];
    int   wraps;
    int   n_seen;
    logic [6:0] prev_phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (rst) begin
            m_cnt      = 0;
            m_acc      = '0;
            m_inc      = '0;
            m_load_cnt = 0;
        end else begin
            if (m_cnt == SrDiv - 1) m_acc = bus.GATE ? m_acc + m_inc : '0;
            m_cnt = (m_cnt == SrDiv - 1) ? 0 : m_cnt + 1;
            if (m_load_cnt > 0) begin
                m_load_cnt--;
                if (m_load_cnt == 0) m_inc = m_inc_pend;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.NOTE_VALID = 1'b0;
        bus.NOTE       = 7'd0;
        bus.GATE       = 1'b1;

        // Reset held for three cycles.
        tick(); tick(); tick();
        chk("rst_ce", bus.CE, 0);
        chk("rst_phase", bus.PHASE, 0);
        chk("rst_inc", bus.INC, 0);
        chk("rst_ready", bus.NOTE_READY, 1);
        rst = 1'b0;

        // CE on the 4th cycle after release, then every 4.
        for (int i = 0; i < 12; i++) begin
            chk("ce_period", bus.CE, ((i % 4) == 3) ? 1 : 0);
            chk("idle_phase", bus.PHASE, 0);
            chk("idle_ready", bus.NOTE_READY, 1);
            tick();
        end

        // NOTE=69 -> INC=0x35D after 8 cycles.
        bus.NOTE_VALID = 1'b1;
        bus.NOTE       = 7'd69;
        chk("n69_ready_pre", bus.NOTE_READY, 1);
        tick();
        bus.NOTE_VALID = 1'b0;
        m_inc_pend     = 24'h00035D;
        m_load_cnt     = 69 / 12 + 3;
        for (int i = 0; i < 8; i++) begin
            chk("n69_busy", bus.NOTE_READY, 0);
            chk("n69_inc_old", bus.INC, 0);
            tick();
        end
        chk("n69_inc", bus.INC, 24'h00035D);
        chk("n69_ready_post", bus.NOTE_READY, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("n69_acc", dut.acc_q, 24'h00035D);

        // NOTE=0 then NOTE=127 held off until the first completes.
        bus.NOTE_VALID = 1'b1;
        bus.NOTE       = 7'd0;
        tick();
        bus.NOTE       = 7'd127;
        m_inc_pend     = 24'h000010;
        m_load_cnt     = 3;
        for (int i = 0; i < 3; i++) begin
            chk("n0_busy", bus.NOTE_READY, 0);
            chk("n0_acc", dut.acc_q, m_acc);
            tick();
        end
        chk("n0_inc", bus.INC, 24'h000010);
        chk("n0_ready", bus.NOTE_READY, 1);
        tick();
        bus.NOTE_VALID = 1'b0;
        m_inc_pend     = 24'h005FE4;
        m_load_cnt     = 127 / 12 + 3;
        for (int i = 0; i < 13; i++) begin
            chk("n127_busy", bus.NOTE_READY, 0);
            chk("n127_acc", dut.acc_q, m_acc);
            tick();
        end
        chk("n127_inc", bus.INC, 24'h005FE4);
        chk("n127_ready", bus.NOTE_READY, 1);

        // Full sweep from ACC=0 with INC=0x5FE4.
        bus.GATE = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("sweep_start_acc", dut.acc_q, 0);
        chk("sweep_start_phase", bus.PHASE, 0);
        bus.GATE   = 1'b1;
        wraps      = 0;
        prev_phase = 7'd0;
        for (int i = 0; i < 128; i++) seen[i] = 1'b0;
        for (int i = 0; i < 690 * 4; i++) begin
            tick();
            chk("sweep_phase", bus.PHASE, m_acc[AccW-1 -: 7]);
            if (bus.PHASE < prev_phase) begin
                wraps++;
                chk("sweep_wrap_zero", bus.PHASE, 0);
            end
            seen[bus.PHASE] = 1'b1;
            prev_phase = bus.PHASE;
        end
        n_seen = 0;
        for (int i = 0; i < 128; i++) if (seen[i]) n_seen++;
        chk("sweep_wraps", wraps, 1);
        chk("sweep_coverage", n_seen, 128);

        // GATE 1->0 mid-ramp, then 0->1 restart.
        for (int i = 0; i < 4 && m_cnt != 0; i++) tick();
        chk("gate_pre_phase", bus.PHASE, m_acc[AccW-1 -: 7]);
        bus.GATE = 1'b0;
        tick(); tick(); tick();
        chk("gate_hold_acc", dut.acc_q, m_acc);
        chk("gate_hold_ce", bus.CE, 1);
        tick();
        chk("gate_off_phase", bus.PHASE, 0);
        chk("gate_off_acc", dut.acc_q, 0);
        bus.GATE = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("gate_on_acc", dut.acc_q, 24'h005FE4);

        // Reset during DIV of NOTE=100.
        bus.NOTE_VALID = 1'b1;
        bus.NOTE       = 7'd100;
        tick();
        bus.NOTE_VALID = 1'b0;
        tick();
        chk("abort_busy", bus.NOTE_READY, 0);
        rst = 1'b1;
        tick();
        chk("abort_ready", bus.NOTE_READY, 1);
        chk("abort_inc", bus.INC, 0);
        chk("abort_phase", bus.PHASE, 0);
        chk("abort_ce", bus.CE, 0);
        rst = 1'b0;
        tick();
        chk("abort_after_ready", bus.NOTE_READY, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
